// File: rtl/tone_pkg.sv
// Shared definitions for the tone burst transmitter and its HearFreq receiver:
// command encodings, controller states and default half-periods at 100 MHz.
package tone_pkg;

  localparam logic [2:0] CMD_500 = 3'b001;
  localparam logic [2:0] CMD_1K  = 3'b010;
  localparam logic [2:0] CMD_1K5 = 3'b100;

  localparam int DEF_HALF_500 = 100_000;
  localparam int DEF_HALF_1K  = 50_000;
  localparam int DEF_HALF_1K5 = 33_333;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TONE = 2'd1,
    GAP  = 2'd2
  } tone_state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/tone_divider.sv
// Half-period counter and square-wave flop. Counts 1..half and toggles at half;
// clear starts a fresh high half, and dropping run parks the output low.
module tone_divider #(
  parameter int HW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          run,
  input  logic [HW-1:0] half,
  output logic          tone,
  output logic          fall_pulse,
  output logic          rise_pulse
);

  logic [HW-1:0] cnt_q, cnt_d;
  logic          tone_q, tone_d;
  logic          at_half;

  // The pulses flag the edge the next clock would produce; they do not depend
  // on run, so the controller can use rise_pulse to veto the final rise.
  assign at_half    = (cnt_q == half);
  assign fall_pulse = at_half & tone_q;
  assign rise_pulse = at_half & ~tone_q;
  assign tone       = tone_q;

  always_comb begin
    cnt_d  = cnt_q;
    tone_d = tone_q;
    if (clear) begin
      cnt_d  = HW'(1);
      tone_d = 1'b1;
    end else if (!run) begin
      cnt_d  = HW'(1);
      tone_d = 1'b0;
    end else if (at_half) begin
      cnt_d  = HW'(1);
      tone_d = ~tone_q;
    end else begin
      cnt_d = cnt_q + HW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= HW'(1);
      tone_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tone_q <= tone_d;
    end
  end

endmodule

// File: rtl/tone_burst_tx.sv
// Tone burst transmitter: accepts a one-hot tone command, plays BURST_PERIODS
// periods of the selected square wave, then holds a silent guard gap.
module tone_burst_tx
  import tone_pkg::*;
#(
  parameter int HALF_500      = DEF_HALF_500,
  parameter int HALF_1K       = DEF_HALF_1K,
  parameter int HALF_1K5      = DEF_HALF_1K5,
  parameter int BURST_PERIODS = 64,
  parameter int GAP_CYCLES    = 1_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [2:0] command,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  output logic       tone,
  output logic       busy,
  output logic       led,
  output logic       done,
  output logic       err
);

  localparam int HW = $clog2(max3(HALF_500, HALF_1K, HALF_1K5) + 1);
  localparam int PW = $clog2(BURST_PERIODS + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  tone_state_t   state_q, state_d;
  logic [HW-1:0] half_q, half_d;
  logic [PW-1:0] period_q, period_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic          handshake;
  logic          cmd_legal;
  logic [HW-1:0] cmd_half;
  logic          div_clear, div_run;
  logic          div_tone, fall_pulse, rise_pulse;
  logic          last_rise;

  assign cmd_ready = (state_q == IDLE) & enable;
  assign handshake = cmd_valid & cmd_ready;
  assign busy      = (state_q != IDLE);
  assign led       = busy;
  assign tone      = div_tone;
  assign done      = done_q;
  assign err       = err_q;

  always_comb begin
    cmd_legal = 1'b1;
    cmd_half  = HW'(HALF_500);
    case (command)
      CMD_500: cmd_half = HW'(HALF_500);
      CMD_1K:  cmd_half = HW'(HALF_1K);
      CMD_1K5: cmd_half = HW'(HALF_1K5);
      default: cmd_legal = 1'b0;
    endcase
  end

  // The burst ends at the rise that would start period BURST_PERIODS+1.
  assign last_rise = rise_pulse && (period_q == PW'(BURST_PERIODS));

  always_comb begin
    state_d   = state_q;
    half_d    = half_q;
    period_d  = period_q;
    gap_d     = gap_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    div_clear = 1'b0;
    div_run   = 1'b0;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (handshake) begin
            if (cmd_legal) begin
              half_d    = cmd_half;
              period_d  = '0;
              gap_d     = '0;
              div_clear = 1'b1;
              state_d   = TONE;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        TONE: begin
          if (last_rise) begin
            gap_d   = GW'(1);
            state_d = GAP;
          end else begin
            div_run = 1'b1;
            if (fall_pulse) period_d = period_q + PW'(1);
          end
        end
        GAP: begin
          if (gap_q == GW'(GAP_CYCLES)) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            gap_d = gap_q + GW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      half_q   <= HW'(HALF_500);
      period_q <= '0;
      gap_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      half_q   <= half_d;
      period_q <= period_d;
      gap_q    <= gap_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  tone_divider #(
    .HW(HW)
  ) u_divider (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (div_clear),
    .run       (div_run),
    .half      (half_q),
    .tone      (div_tone),
    .fall_pulse(fall_pulse),
    .rise_pulse(rise_pulse)
  );

endmodule
